// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
// Bundles the signals that connect the instruction fetch unit to the
// instruction memory, the control FSM that consumes instructions, and the
// fetch control inputs.
//   master modport : the fetch unit side
//   slave modport  : the environment side (memory + control FSM)
// Signals:
//   en                    fetch enable
//   imem_req/imem_addr    read request and address toward instruction memory
//   imem_rdata/rvalid     in-order read response
//   instr_valid/ready     head-of-FIFO handshake toward the control FSM
//   instr/instr_pc        head instruction and its address
//   redirect/redirect_pc  load a new PC and flush
//   halt_req/halted       stop fetching / halt status
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              en;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_rvalid;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              halted;

  modport master (
    input  en, imem_rdata, imem_rvalid, instr_ready, redirect, redirect_pc, halt_req,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, halted
  );

  modport slave (
    output en, imem_rdata, imem_rvalid, instr_ready, redirect, redirect_pc, halt_req,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Owns the program counter, issues in-order requests to a variable-latency
// instruction memory, buffers returned instructions in a small prefetch FIFO
// and hands them to the control FSM over a valid/ready handshake.
// Supports redirect (load PC + flush) and halt (stop fetching + flush).
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  instr_fetch_unit_if master modport (memory, consumer and control)
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 2;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic              pop;
  logic              flush;
  logic              rsp_tracked;
  logic              rsp_keep;
  logic              req;
  logic [SW-1:0]     occupancy;
  logic [ADDR_W-1:0] rsp_addr;

  // Responses are only acted on when some request is tracked; discards are
  // always older than kept requests, so they are consumed first.
  assign pop         = (count != '0) & bus.instr_ready;
  assign flush       = bus.redirect | ((state == RUN) & bus.halt_req);
  assign rsp_tracked = bus.imem_rvalid & ((outstanding != '0) | (discard != '0));
  assign rsp_keep    = rsp_tracked & (discard == '0) & ~flush;
  assign occupancy   = SW'(count) + SW'(outstanding) + SW'(discard);
  assign req         = (state == RUN) & bus.en & ~bus.redirect & ~bus.halt_req
                       & (occupancy < SW'(DEPTH));

  // Kept requests are the most recent ones issued since the last flush and
  // were issued to consecutive addresses, so the oldest one is pc - outstanding.
  assign rsp_addr = pc - ADDR_W'(outstanding);

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = data_mem[rd_ptr];
  assign bus.instr_pc    = addr_mem[rd_ptr];
  assign bus.halted      = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Redirect wins over halt_req and decides RUN/IDLE from en in every state.
  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = bus.en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.en) state_next = RUN;
        RUN: begin
          if (bus.halt_req)  state_next = HALT;
          else if (!bus.en)  state_next = IDLE;
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // On a flush every in-flight request becomes a discard; a coincident
  // response consumes one of them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (bus.redirect) pc <= bus.redirect_pc;
      else if (req)     pc <= pc + ADDR_W'(1);

      if (flush) begin
        outstanding <= '0;
        discard     <= discard + outstanding - CW'(rsp_tracked);
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (rsp_tracked && (discard != '0)) discard <= discard - CW'(1);
        outstanding <= outstanding + CW'(req) - CW'(rsp_keep);
        count       <= count + CW'(rsp_keep) - CW'(pop);
        if (pop)      rd_ptr <= rd_ptr + PW'(1);
        if (rsp_keep) wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Storage is cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (rsp_keep) begin
      data_mem[wr_ptr] <= bus.imem_rdata;
      addr_mem[wr_ptr] <= rsp_addr;
    end
  end

  rsp_orphan: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> ((outstanding != '0) || (discard != '0)));

endmodule
